resonator_dds_cmix_round: RTL and testbench
===========================================

RESONATOR_DDS_CMIX_ROUND -- requirements
Module: resonator_dds_cmix_round

Interface
REQ-001 SHALL have parameter SHIFT, default 16, meaning the arithmetic right-shift applied to each 34-bit sum before rounding.
REQ-002 SHALL have parameter ID, default 1, meaning the instance tag; it SHALL NOT affect function.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port din_valid, input, 1, meaning the four products are valid this cycle.
REQ-006 SHALL have port din_ready, output, 1, meaning the block accepts products this cycle.
REQ-007 SHALL have ports p_ac, p_bd, p_ad, p_bc, each input, 33, signed multiplier products.
REQ-008 SHALL have port dout_valid, output, 1, meaning the output sample is valid.
REQ-009 SHALL have port dout_ready, input, 1, meaning downstream accepts the sample.
REQ-010 SHALL have port dout_re, output, 16, signed real result.
REQ-011 SHALL have port dout_im, output, 16, signed imaginary result.
REQ-012 SHALL have port ovf, output, 1, a sticky overflow flag.
REQ-013 SHALL have port ovf_clr, input, 1, which clears ovf.

Function
REQ-014 SHALL accept an input beat only when din_valid and din_ready are both 1, and SHALL emit an output beat only when dout_valid and dout_ready are both 1.
REQ-015 Stage 1 SHALL register re34 = p_ac - p_bd and im34 = p_ad + p_bc at full 34-bit signed width, with no truncation.
REQ-016 Stage 2 SHALL register the rounded value (x + 2^(SHIFT-1)) >>> SHIFT for each 34-bit sum (round half up, arithmetic shift), then reduce it to 16 bits per REQ-026/027.
REQ-017 Latency from an accepted input to dout_valid SHALL be exactly 2 cycles when dout_ready is held at 1.
REQ-018 Throughput SHALL be one beat per cycle when dout_ready is held at 1.
REQ-019 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or when its content moves on in the same cycle.
REQ-020 din_ready SHALL equal (!s1_valid || s2 loads this cycle); s2 loads when !dout_valid || dout_ready.
REQ-021 Bubbles SHALL collapse: an empty stage-2 SHALL accept stage-1 data even while dout_ready is 0.
REQ-022 When dout_valid=1 and dout_ready=0, dout_re and dout_im SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-023 Beat order SHALL be preserved, and no beat SHALL be dropped.
REQ-024 ovf SHALL set on the cycle after a stage-2 load in which either channel overflowed the 16-bit range.
REQ-025 ovf_clr SHALL clear ovf; when a clear and a new overflow occur in the same cycle, set SHALL win.

Configuration
REQ-026 With RESONATOR_DDS_SAT_EN defined, out-of-range results SHALL saturate to +32767 or -32768.
REQ-027 Without RESONATOR_DDS_SAT_EN, results SHALL wrap (low 16 bits kept), and ovf SHALL still report the overflow condition.

Reset
REQ-028 While reset=1, s1_valid, dout_valid and ovf SHALL be 0 on the next edge.
REQ-029 While reset=1, dout_re and dout_im SHALL be 0 and din_ready SHALL be 1 after that edge.
REQ-030 Reset mid-stream SHALL discard all in-flight beats, with no beat emitted afterward from pre-reset input.
REQ-031 Reset SHALL take priority over ovf_clr and over all handshakes.

Verification (SHIFT=16)
REQ-032 Stimulus p_ac=196608, p_bd=65536, p_ad=65536, p_bc=65536, dout_ready=1 SHALL give dout_re=2 and dout_im=2 two cycles later, with ovf=0.
REQ-033 Stimulus p_ac=32768 (others 0) SHALL give dout_re=1; stimulus p_ac=-32768 SHALL give dout_re=0 (rounding check).
REQ-034 Stimulus p_ac=2^31, p_bd=-2^31 SHALL give dout_re=32767 and ovf=1 with the macro defined, and dout_re=0 and ovf=1 without it.
REQ-035 Stimulus of 8 consecutive beats with dout_ready toggled 1,0,0,1 SHALL produce all 8 outputs in order; din_ready SHALL fall only when both stages are full and stalled.
REQ-036 Asserting reset with 2 beats in flight SHALL give dout_valid=0 on the next cycle; no stale beat SHALL appear, and ovf=0.
REQ-037 Stimulus ovf_clr=1 in the same cycle as a new overflow SHALL leave ovf=1; ovf_clr alone SHALL give ovf=0 on the next cycle.

Source files
------------

// File: rtl/resonator_dds_cmix_round.sv
// Two-stage complex-mix combine/round: re=ac-bd, im=ad+bc, then round, shift and reduce to 16 bits.
// Define RESONATOR_DDS_SAT_EN to saturate out-of-range results; otherwise they wrap.
module resonator_dds_cmix_round #(
  parameter int SHIFT = 16,
  parameter int ID    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [32:0] p_ac,
  input  logic [32:0] p_bd,
  input  logic [32:0] p_ad,
  input  logic [32:0] p_bc,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] dout_re,
  output logic [15:0] dout_im,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int unused_id = ID;
  localparam logic signed [34:0] RND = 35'sd1 <<< (SHIFT - 1);

  logic               s1_valid;
  logic signed [33:0] re34;
  logic signed [33:0] im34;
  logic               s2_load;
  logic [16:0]        rr;
  logic [16:0]        ri;

  // One extra bit of headroom so adding the rounding constant never wraps.
  function automatic logic [16:0] reduce(input logic [33:0] x);
    logic signed [34:0] t;
    logic               hi;
    logic               lo;
    logic [15:0]        v;
    t  = ($signed({x[33], x}) + RND) >>> SHIFT;
    hi = t > 35'sd32767;
    lo = t < -35'sd32768;
`ifdef RESONATOR_DDS_SAT_EN
    v = hi ? 16'h7fff : (lo ? 16'h8000 : t[15:0]);
`else
    v = t[15:0];
`endif
    return {hi | lo, v};
  endfunction

  assign s2_load   = !dout_valid || dout_ready;
  assign din_ready = !s1_valid || s2_load;

  always_comb begin
    rr = reduce(re34);
    ri = reduce(im34);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      re34     <= '0;
      im34     <= '0;
    end else if (din_ready) begin
      s1_valid <= din_valid;
      if (din_valid) begin
        re34 <= $signed({p_ac[32], p_ac}) - $signed({p_bd[32], p_bd});
        im34 <= $signed({p_ad[32], p_ad}) + $signed({p_bc[32], p_bc});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      ovf        <= 1'b0;
    end else begin
      if (s2_load) begin
        dout_valid <= s1_valid;
        if (s1_valid) begin
          dout_re <= rr[15:0];
          dout_im <= ri[15:0];
        end
      end
      // A fresh overflow beats a simultaneous clear.
      if (s2_load && s1_valid && (rr[16] || ri[16]))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_resonator_dds_cmix_round.sv
// Randomized bench for resonator_dds_cmix_round with a queue-based reference model.
// Directed beats pin the rounding, overflow, stall, reset and ovf_clr behaviour.
module tb_resonator_dds_cmix_round;

  localparam int SHIFT = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic signed [32:0] p_ac = '0;
  logic signed [32:0] p_bd = '0;
  logic signed [32:0] p_ad = '0;
  logic signed [32:0] p_bc = '0;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic signed [15:0] dout_re;
  logic signed [15:0] dout_im;
  logic               ovf;
  logic               ovf_clr = 1'b0;

  resonator_dds_cmix_round #(.SHIFT(SHIFT), .ID(3)) dut (
    .clk(clk), .reset(reset),
    .din_valid(din_valid), .din_ready(din_ready),
    .p_ac(p_ac), .p_bd(p_bd), .p_ad(p_ad), .p_bc(p_bc),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_re(dout_re), .dout_im(dout_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    bit     of;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     occ = 0;
  bit     ovf_seen = 0;
  bit     chk_ovf = 0;
  bit     stall = 0;
  longint prev_re = 0;
  longint prev_im = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint rnd_shift(input longint s, output bit of);
    longint r;
    r  = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    of = (r > 32767) || (r < -32768);
`ifdef RESONATOR_DDS_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    r = r & 65535;
    if (r > 32767) r = r - 65536;
`endif
    return r;
  endfunction

  function automatic exp_t model(input longint ac, bd, ad, bc);
    exp_t e;
    bit   o1;
    bit   o2;
    e.re = rnd_shift(ac - bd, o1);
    e.im = rnd_shift(ad + bc, o2);
    e.of = o1 | o2;
    return e;
  endfunction

  always @(negedge clk) begin
    bit   acc;
    bit   emit;
    exp_t e;
    if (reset) begin
      q.delete();
      occ = 0;
      ovf_seen = 0;
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", longint'(dout_valid), 1);
        chk("hold_re", longint'(dout_re), prev_re);
        chk("hold_im", longint'(dout_im), prev_im);
      end
      chk("din_ready", longint'(din_ready), longint'(!(occ == 2 && !dout_ready)));
      acc  = din_valid && din_ready;
      emit = dout_valid && dout_ready;
      if (emit) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got re=%0d im=%0d expected none", dout_re, dout_im);
        end else begin
          e = q.pop_front();
          chk("out_re", longint'(dout_re), e.re);
          chk("out_im", longint'(dout_im), e.im);
          if (chk_ovf) begin
            ovf_seen = ovf_seen | e.of;
            chk("ovf_sticky", longint'(ovf), longint'(ovf_seen));
          end
        end
      end
      if (acc) q.push_back(model(p_ac, p_bd, p_ad, p_bc));
      occ = occ + int'(acc) - int'(emit);
      stall = dout_valid && !dout_ready;
      prev_re = longint'(dout_re);
      prev_im = longint'(dout_im);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint ac, bd, ad, bc);
    p_ac = 33'(ac);
    p_bd = 33'(bd);
    p_ad = 33'(ad);
    p_bc = 33'(bc);
  endtask

  // Present one beat with dout_ready high; returns once the result should be visible.
  task automatic beat(input longint ac, bd, ad, bc);
    dout_ready = 1'b1;
    drive(ac, bd, ad, bc);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string nm);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (6) tick();
    chk(nm, longint'(q.size()), 0);
  endtask

  function automatic logic signed [32:0] rnd33();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return 33'(longint'($urandom_range(0, 400000)) - 200000);
      1: return 33'($signed(w[25:0]));
      2: return 33'($signed(w[31:0]));
      default: return w[32:0];
    endcase
  endfunction

  initial begin
    int acc_n;
    int cyc;
    bit [3:0] pat;
    longint ovf_re;

    repeat (2) tick();
    chk("rst_valid", longint'(dout_valid), 0);
    chk("rst_ready", longint'(din_ready), 1);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_re", longint'(dout_re), 0);
    chk("rst_im", longint'(dout_im), 0);
    reset = 1'b0;
    tick();

    beat(196608, 65536, 65536, 65536);
    chk("lat_valid", longint'(dout_valid), 1);
    chk("basic_re", longint'(dout_re), 2);
    chk("basic_im", longint'(dout_im), 2);
    chk("basic_ovf", longint'(ovf), 0);

    beat(32768, 0, 0, 0);
    chk("round_up_re", longint'(dout_re), 1);
    beat(-32768, 0, 0, 0);
    chk("round_neg_re", longint'(dout_re), 0);

`ifdef RESONATOR_DDS_SAT_EN
    ovf_re = 32767;
`else
    ovf_re = 0;
`endif
    beat(longint'(1) << 31, -(longint'(1) << 31), 0, 0);
    chk("ovf_re", longint'(dout_re), ovf_re);
    chk("ovf_set", longint'(ovf), 1);
    drain("drain_directed");

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", longint'(ovf), 0);

    drive(longint'(1) << 31, -(longint'(1) << 31), 0, 0);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", longint'(ovf), 1);
    drain("drain_ovf");

    pat = 4'b1001;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 8 && cyc < 100) begin
      dout_ready = pat[3 - (cyc % 4)];
      drive(longint'(acc_n + 1) << 17, 0, longint'(acc_n + 1) << 16, 0);
      din_valid = 1'b1;
      #1;
      if (din_ready) acc_n++;
      tick();
      cyc++;
    end
    chk("stall_accepted", longint'(acc_n), 8);
    drain("drain_stall");

    drive(longint'(1) << 31, 0, 65536, 0);
    dout_ready = 1'b0;
    din_valid = 1'b1;
    tick();
    drive(131072, 0, 0, 0);
    tick();
    din_valid = 1'b0;
    chk("inflight_occ", longint'(occ), 2);
    reset = 1'b1;
    tick();
    chk("midrst_valid", longint'(dout_valid), 0);
    chk("midrst_ovf", longint'(ovf), 0);
    chk("midrst_ready", longint'(din_ready), 1);
    reset = 1'b0;
    dout_ready = 1'b1;
    repeat (5) tick();
    chk("midrst_no_stale", longint'(dout_valid), 0);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_seen = 0;
    chk_ovf = 1;
    for (int i = 0; i < 1500; i++) begin
      din_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      drive(rnd33(), rnd33(), rnd33(), rnd33());
      tick();
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
